// File: rtl/moore_seq_pkg.sv
// Shared types for the "110" Moore sequence detector.
// State codes are Gray when MOORE_GRAY_STATE_EN is defined, plain binary otherwise.
package moore_seq_pkg;

`ifdef MOORE_GRAY_STATE_EN
    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b11,
        S3 = 2'b10
    } stateT;
`else
    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } stateT;
`endif

    // Z is a pure function of the state code, so it stays a Moore output.
    function automatic logic zDecode(input stateT s);
        return (s == S3);
    endfunction

endpackage

// File: rtl/state_reg2_sync.sv
// Two-flip-flop state stage for the Moore detector.
// Synchronous active-high reset returns the stage to S0.
module state_reg2_sync
    import moore_seq_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  stateT nextY,
    output stateT y
);

    always_ff @(posedge clk) begin
        if (reset) begin
            y <= S0;
        end else begin
            y <= nextY;
        end
    end

endmodule

// File: rtl/moore_seq_ctrl.sv
// "110" serial pattern detector with sample qualification, idle timeout and a
// saturating detection counter. Define MOORE_GRAY_STATE_EN for Gray state codes.
module moore_seq_ctrl
    import moore_seq_pkg::*;
#(
    parameter int COUNT_W = 8,
    parameter int TIMEOUT = 16,
    parameter int IDLE_W  = 5
) (
    input  logic               inputClk,
    input  logic               inputR,
    input  logic               inputX,
    input  logic               inputValid,
    input  logic               inputClr,
    output logic [1:0]         outputy,
    output logic               outputZ,
    output logic [COUNT_W-1:0] outputCount,
    output logic               outputTimeout
);

    localparam bit                  TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [IDLE_W-1:0]   IDLE_LIMIT = TIMEOUT_EN ? IDLE_W'(TIMEOUT - 1) : '0;
    localparam logic [COUNT_W-1:0]  COUNT_MAX  = '1;

    stateT              curY;
    stateT              nextY;
    logic               timeoutHit;
    logic               enterS3;
    logic [IDLE_W-1:0]  idleCount;
    logic [COUNT_W-1:0] countReg;
    logic               zReg;
    logic               timeoutReg;

    state_reg2_sync stateStage (
        .clk   (inputClk),
        .reset (inputR),
        .nextY (nextY),
        .y     (curY)
    );

    // A valid sample always beats the timeout; an unqualified cycle holds state.
    always_comb begin
        timeoutHit = 1'b0;
        nextY      = curY;
        if (TIMEOUT_EN && (curY != S0) && !inputValid && (idleCount == IDLE_LIMIT)) begin
            timeoutHit = 1'b1;
        end
        if (timeoutHit) begin
            nextY = S0;
        end else if (inputValid) begin
            case (curY)
                S0:      nextY = inputX ? S1 : S0;
                S1:      nextY = inputX ? S2 : S0;
                S2:      nextY = inputX ? S2 : S3;
                S3:      nextY = inputX ? S1 : S0;
                default: nextY = S0;
            endcase
        end
    end

    assign enterS3 = (nextY == S3) && (curY != S3);

    // Z and the timeout pulse are registered from the next state so they line up
    // with the state register; the idle counter saturates when timeout is disabled.
    always_ff @(posedge inputClk) begin
        if (inputR) begin
            idleCount  <= '0;
            countReg   <= '0;
            zReg       <= 1'b0;
            timeoutReg <= 1'b0;
        end else begin
            zReg       <= zDecode(nextY);
            timeoutReg <= timeoutHit;

            if (timeoutHit || inputValid || (curY == S0)) begin
                idleCount <= '0;
            end else if (idleCount != '1) begin
                idleCount <= idleCount + 1'b1;
            end

            if (inputClr) begin
                countReg <= '0;
            end else if (enterS3 && (countReg != COUNT_MAX)) begin
                countReg <= countReg + 1'b1;
            end
        end
    end

    assign outputy       = curY;
    assign outputZ       = zReg;
    assign outputCount   = countReg;
    assign outputTimeout = timeoutReg;

endmodule

// File: tb/tb_moore_seq_ctrl.sv
// Self-checking bench for moore_seq_ctrl: directed scenarios plus random stimulus
// compared each cycle against a bit-history reference model.
module tb_moore_seq_ctrl;

    localparam int COUNT_W = 2;
    localparam int TIMEOUT = 16;
    localparam int IDLE_W  = 5;
    localparam int CNT_MAX = (1 << COUNT_W) - 1;

    logic               clk = 1'b0;
    logic               inputR;
    logic               inputX;
    logic               inputValid;
    logic               inputClr;
    logic [1:0]         outputy;
    logic               outputZ;
    logic [COUNT_W-1:0] outputCount;
    logic               outputTimeout;

    int checks = 0;
    int errors = 0;

    // Reference model: the last three valid bits since reset/timeout decide the state.
    int       histLen   = 0;
    bit [2:0] hist      = 3'b000;
    int       idleRun   = 0;
    int       expCount  = 0;
    bit       expTimeout = 1'b0;
    int       pulseTally = 0;

    moore_seq_ctrl #(
        .COUNT_W (COUNT_W),
        .TIMEOUT (TIMEOUT),
        .IDLE_W  (IDLE_W)
    ) dut (
        .inputClk      (clk),
        .inputR        (inputR),
        .inputX        (inputX),
        .inputValid    (inputValid),
        .inputClr      (inputClr),
        .outputy       (outputy),
        .outputZ       (outputZ),
        .outputCount   (outputCount),
        .outputTimeout (outputTimeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int modelStage();
        if (histLen >= 3 && hist == 3'b110) return 3;
        if (histLen >= 2 && hist[1:0] == 2'b11) return 2;
        if (histLen >= 1 && hist[0]) return 1;
        return 0;
    endfunction

    function automatic logic [1:0] stageCode(input int s);
`ifdef MOORE_GRAY_STATE_EN
        case (s)
            0: return 2'b00;
            1: return 2'b01;
            2: return 2'b11;
            default: return 2'b10;
        endcase
`else
        return 2'(s);
`endif
    endfunction

    task automatic modelStep(input bit r, input bit x, input bit v, input bit c);
        int prevStage;
        int newStage;
        prevStage  = modelStage();
        expTimeout = 1'b0;
        if (r) begin
            histLen  = 0;
            hist     = 3'b000;
            idleRun  = 0;
            expCount = 0;
        end else begin
            if (v) begin
                hist    = {hist[1:0], x};
                histLen = (histLen < 3) ? histLen + 1 : 3;
                idleRun = 0;
            end else if (prevStage != 0) begin
                idleRun++;
                if (idleRun == TIMEOUT) begin
                    histLen    = 0;
                    hist       = 3'b000;
                    idleRun    = 0;
                    expTimeout = 1'b1;
                end
            end else begin
                idleRun = 0;
            end
            newStage = modelStage();
            if (c) begin
                expCount = 0;
            end else if (newStage == 3 && prevStage != 3 && expCount < CNT_MAX) begin
                expCount++;
            end
        end
    endtask

    task automatic applyStimulus(input string tag, input bit r, input bit x,
                                 input bit v, input bit c);
        inputR     = r;
        inputX     = x;
        inputValid = v;
        inputClr   = c;
        @(posedge clk);
        #1;
        modelStep(r, x, v, c);
        if (outputTimeout === 1'b1) pulseTally++;
        checkOutput({tag, ".y"}, 32'(outputy), 32'(stageCode(modelStage())));
        checkOutput({tag, ".z"}, 32'(outputZ), 32'(modelStage() == 3));
        checkOutput({tag, ".count"}, 32'(outputCount), 32'(expCount));
        checkOutput({tag, ".timeout"}, 32'(outputTimeout), 32'(expTimeout));
    endtask

    task automatic sendBits(input string tag, input bit [7:0] bits, input int n,
                            input bit clrLast);
        for (int i = n - 1; i >= 0; i--) begin
            applyStimulus(tag, 1'b0, bits[i], 1'b1, clrLast && (i == 0));
        end
    endtask

    initial begin
        inputR     = 1'b1;
        inputX     = 1'b1;
        inputValid = 1'b1;
        inputClr   = 1'b0;

        // Reset held two cycles with X=1 and valid asserted
        applyStimulus("reset0", 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus("reset1", 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("reset.y", 32'(outputy), 32'(stageCode(0)));
        checkOutput("reset.count", 32'(outputCount), 32'd0);

        // Basic detect
        sendBits("basic", 8'b110, 3, 1'b0);
        checkOutput("basic.z", 32'(outputZ), 32'd1);
        checkOutput("basic.count", 32'(outputCount), 32'd1);

        // Stream 1110110: two detects, none on the middle 111
        applyStimulus("rst2", 1'b1, 1'b0, 1'b0, 1'b0);
        pulseTally = 0;
        begin
            int zHigh;
            bit [6:0] stream;
            zHigh  = 0;
            stream = 7'b1110110;
            for (int i = 6; i >= 0; i--) begin
                applyStimulus("stream", 1'b0, stream[i], 1'b1, 1'b0);
                if (outputZ === 1'b1) zHigh++;
            end
            checkOutput("stream.zCycles", 32'(zHigh), 32'd2);
            checkOutput("stream.count", 32'(outputCount), 32'd2);
        end

        // Gaps between valid samples still reach S3
        applyStimulus("rst3", 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("gap", 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus("gapIdle", 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("gap", 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus("gap", 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("gap.y", 32'(outputy), 32'(stageCode(3)));
        checkOutput("gap.count", 32'(outputCount), 32'd1);

        // Timeout from S2 after 16 idle cycles
        sendBits("toPrep", 8'b11, 2, 1'b0);
        pulseTally = 0;
        for (int i = 0; i < TIMEOUT + 2; i++) applyStimulus("toIdle", 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("timeout.pulses", 32'(pulseTally), 32'd1);
        checkOutput("timeout.y", 32'(outputy), 32'(stageCode(0)));

        // Valid sample on the would-be timeout cycle wins
        sendBits("toRace", 8'b11, 2, 1'b0);
        for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus("raceIdle", 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("race", 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("race.y", 32'(outputy), 32'(stageCode(2)));

        // Saturation and clear-wins
        applyStimulus("rst4", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int d = 0; d < 4; d++) sendBits("sat", 8'b110, 3, 1'b0);
        checkOutput("sat.count", 32'(outputCount), 32'(CNT_MAX));
        sendBits("satClr", 8'b110, 3, 1'b1);
        checkOutput("satClr.count", 32'(outputCount), 32'd0);

        // Reset mid-pattern: in S2, reset with X=0 valid=1
        sendBits("mid", 8'b110, 3, 1'b0);
        sendBits("mid", 8'b11, 2, 1'b0);
        applyStimulus("midReset", 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("midReset.y", 32'(outputy), 32'(stageCode(0)));
        checkOutput("midReset.count", 32'(outputCount), 32'd0);

        // Random stimulus with occasional long idle bursts
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                int len;
                len = $urandom_range(10, 20);
                for (int k = 0; k < len; k++) begin
                    applyStimulus("rndIdle", 1'b0, 1'($urandom), 1'b0,
                                  ($urandom_range(0, 29) == 0));
                end
            end else begin
                applyStimulus("rnd", ($urandom_range(0, 99) == 0), 1'($urandom),
                              ($urandom_range(0, 9) < 7), ($urandom_range(0, 29) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
